// File: rtl/ptp_tsu_pkg.sv
// Shared definitions for the PTP timestamp unit.
// Entry layout: msgid, seqid, then 80-bit timestamp.
package ptp_tsu_pkg;

    localparam int PTP_INFOR_W = 92;

    localparam int MSGID_HI  = 91;
    localparam int MSGID_LO  = 88;
    localparam int SEQID_HI  = 87;
    localparam int SEQID_LO  = 80;
    localparam int TS_SEC_HI = 79;
    localparam int TS_SEC_LO = 32;
    localparam int TS_NS_HI  = 31;
    localparam int TS_NS_LO  = 0;

    typedef logic [PTP_INFOR_W-1:0] ptp_infor_t;

    typedef struct packed {
        logic [3:0]  msgid;
        logic [7:0]  seqid;
        logic [47:0] ts_sec;
        logic [31:0] ts_ns;
    } ptp_fields_t;

    function automatic logic [7:0] get_seqid(input ptp_infor_t e);
        return e[SEQID_HI:SEQID_LO];
    endfunction

endpackage

// File: rtl/ptp_sync_fifo.sv
// Generic single-clock register FIFO with count-based occupancy.
// Clear has priority over push and pop.
import ptp_tsu_pkg::*;

module ptp_sync_fifo #(
    parameter int WIDTH = PTP_INFOR_W,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [AW:0]      count_o,
    output logic [AW:0]      count_nxt_o,
    output logic             push_ok_o,
    output logic             pop_ok_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    always_comb begin
        pop_ok   = pop_i & ~empty_o & ~clr_i;
        // A full FIFO still takes a push when a pop frees the slot.
        push_ok  = push_i & (~full_o | pop_ok) & ~clr_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (push_ok && !pop_ok)
                count_d = count_q + (AW+1)'(1);
            else if (pop_ok && !push_ok)
                count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;
    assign push_ok_o   = push_ok;
    assign pop_ok_o    = pop_ok;

endmodule

// File: rtl/ptp_ts_queue.sv
// PTP timestamp queue: FIFO of parser entries with host status.
// Adds saturating overflow count, sticky underflow and irq flop.
import ptp_tsu_pkg::*;

module ptp_ts_queue #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ptp_found,
    input  logic [PTP_INFOR_W-1:0] ptp_infor,
    input  logic                   q_rd,
    input  logic                   q_clear,
    output logic [PTP_INFOR_W-1:0] q_rd_data,
    output logic                   q_empty,
    output logic                   q_full,
    output logic [AW:0]            q_count,
    output logic [7:0]             q_ovf_cnt,
    output logic                   q_udf,
    output logic                   q_irq
);

    localparam logic [AW:0] IRQ_LVL = (AW+1)'(IRQ_LEVEL);

    logic [AW:0] count_nxt;
    logic        push_ok;
    logic        pop_ok;
    logic [7:0]  ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        irq_q, irq_d;

    ptp_sync_fifo #(
        .WIDTH (PTP_INFOR_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (q_clear),
        .push_i      (ptp_found),
        .pop_i       (q_rd),
        .din_i       (ptp_infor),
        .dout_o      (q_rd_data),
        .count_o     (q_count),
        .count_nxt_o (count_nxt),
        .push_ok_o   (push_ok),
        .pop_ok_o    (pop_ok),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        irq_d = (count_nxt >= IRQ_LVL);
        if (q_clear) begin
            ovf_d = '0;
            udf_d = 1'b0;
        end else begin
            // A rejected push can only mean the FIFO was full.
            if (ptp_found && !push_ok && ovf_q != 8'hFF)
                ovf_d = ovf_q + 8'd1;
            if (q_rd && q_empty)
                udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            irq_q <= irq_d;
        end
    end

    assign q_ovf_cnt = ovf_q;
    assign q_udf     = udf_q;
    assign q_irq     = irq_q;

endmodule

// File: doc/ptp_ts_queue.md
# ptp_ts_queue

Timestamp queue for the TSU receive/transmit path. It sits directly downstream of the PTP frame parser. Each single-cycle `ptp_found` pulse pushes the parser's 92-bit information word (message id, sequence id, 80-bit timestamp) into a FIFO. Host-side register logic reads the FIFO in the same clock domain and receives occupancy, overflow, underflow and interrupt status.

## Interface
Parameters:
- `DEPTH`, 16 — number of entries; power of two, 2..256.
- `AW`, 4 — `log2(DEPTH)`.
- `IRQ_LEVEL`, 1 — occupancy at or above which `q_irq` asserts; range 1..DEPTH.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `ptp_found` in 1 — push strobe, one cycle per qualifying frame.
- `ptp_infor` in 92 — entry: [91:88] msgid, [87:80] seqid, [79:0] timestamp (48b seconds, 32b ns).
- `q_rd` in 1 — pop strobe from host register logic.
- `q_clear` in 1 — synchronous flush.
- `q_rd_data` out 92 — head entry; valid while `q_empty`=0.
- `q_empty` out 1 — FIFO empty.
- `q_full` out 1 — FIFO full.
- `q_count` out AW+1 — occupancy, 0..DEPTH.
- `q_ovf_cnt` out 8 — dropped-push count; saturates at 255.
- `q_udf` out 1 — sticky: a pop arrived while empty.
- `q_irq` out 1 — registered, high while `q_count` ≥ `IRQ_LEVEL`.

## Operation
- Storage is a DEPTH×92 register array with read pointer `rd_ptr` and write pointer `wr_ptr`, each AW bits, both wrapping modulo DEPTH.
- Occupancy is tracked by `count` (AW+1 bits), not by pointer comparison.
- Per-cycle priority:
  1. `q_clear`: pointers, `count`, `q_ovf_cnt` and `q_udf` go to 0. Any push or pop in the same cycle is ignored.
  2. Push accepted: `ptp_found`=1 and (`count`<DEPTH, or a pop is accepted in the same cycle). Then `mem[wr_ptr]`←`ptp_infor` and `wr_ptr`++.
  3. Pop accepted: `q_rd`=1 and `count`>0. Then `rd_ptr`++.
  4. `count` changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- Full, push without pop: the entry is dropped, FIFO contents are unchanged, and `q_ovf_cnt` increments unless it is already 255.
- Full, push with pop: both are accepted and `count` stays DEPTH. No overflow.
- Empty, pop: ignored and `q_udf` is set. An empty push with a simultaneous pop accepts the push only.
- `q_rd_data` = `mem[rd_ptr]`, a mux driven from registers. When empty it holds the last stale value, which is don't-care.
- `q_empty` = (`count`==0), `q_full` = (`count`==DEPTH), combinational from the `count` register.
- `q_irq` flop is loaded each cycle with (`next_count` ≥ `IRQ_LEVEL`).
- No filtering on msgid. Every `ptp_found` pulse is queued.

## Timing
- Reset values:
  - `q_empty`=1.
  - `q_full`=0, `q_count`=0, `q_ovf_cnt`=0, `q_udf`=0, `q_irq`=0.
  - `q_rd_data`=0; memory is reset to 0.
- Push at edge N into an empty FIFO: `q_empty`=0, `q_count`=1, `q_irq`=1 (with `IRQ_LEVEL`=1) and `q_rd_data` = the pushed entry, all visible after edge N.
  - Latency is one cycle.
- Pop at edge N: the next entry appears on `q_rd_data` after edge N. Back-to-back pops every cycle are allowed.
- `ptp_found` needs no handshake. A new push every cycle is sustainable.
- Reset mid-operation: all state returns to its reset values immediately. Queued entries are lost.
- `q_clear` takes effect at the next edge. The FIFO accepts pushes again from the cycle after the clear.

## Structure
- Shared package `ptp_tsu_pkg` holds:
  - `PTP_INFOR_W`=92.
  - Field bit positions: MSGID_HI/LO, SEQID_HI/LO, TS_SEC_HI/LO, TS_NS_HI/LO.
  - `typedef ptp_infor_t`.
- One sub-module, `ptp_sync_fifo`: a generic single-clock FIFO (WIDTH, DEPTH) with push, pop, count and clear.
- `ptp_ts_queue` wraps `ptp_sync_fifo` and adds the overflow counter, underflow flag and interrupt flop.

## Test plan
- Reset, then push one entry `{4'h0, 8'h2A, 80'h0000_0001_0000_0000_0064}`:
  - After one edge: `q_empty`=0, `q_count`=1, `q_irq`=1, and `q_rd_data` equals the pushed entry.
  - Pop: `q_empty`=1, `q_count`=0.
- Push 16 entries with seqid 0..15:
  - `q_full`=1, `q_count`=16.
  - Push seqid 16: `q_ovf_cnt`=1.
  - 16 pops return seqid 0..15 in order; seqid 16 never appears.
- Full FIFO, simultaneous push (seqid 99) and pop:
  - `q_count` stays 16, `q_ovf_cnt` is unchanged.
  - The tail entry after the remaining 16 pops is seqid 99.
- Pop while empty: `q_udf`=1, `q_count` stays 0. `q_clear` then returns `q_udf` to 0.
- 300 pushes into a full FIFO: `q_ovf_cnt` saturates at 255. `q_clear` together with a push in the same cycle: `q_count`=0 afterwards.
- Assert `rst` mid-burst with 5 entries queued: all outputs take their reset values before the next `clk` edge.
